instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Fetch/decode/execute control FSM for the 16-bit accumulator machine.
//  - Sits between MainMemory and the ALU; owns PC, IR, MBR and ACC.
//  - Drives memory address/write and the ALU opcode/operands.
//  - Commits ALU results into ACC.
// PARAMETERS
//  ADDR_W    14  memory address width (16Ki words)
//  DATA_W    16  data/instruction width
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  reset         in   1       asynchronous, active-low reset
//  run           in   1       1 = leave FETCH; 0 = hold in FETCH
//  mem_addr      out  ADDR_W  MainMemory address
//  mem_wdata     out  DATA_W  MainMemory write data (always = ACC)
//  mem_we        out  1       MainMemory write enable
//  mem_rdata     in   DATA_W  MainMemory data_out, valid the cycle after addr presented
//  alu_opcode    out  4       ALU operation code
//  alu_operand1  out  DATA_W  always ACC
//  alu_operand2  out  DATA_W  always MBR
//  alu_result    in   DATA_W  ALU combinational result
//  pc            out  ADDR_W  program counter
//  acc           out  DATA_W  accumulator
//  halted        out  1       1 while in HALTED
//  retire        out  1       1-cycle pulse when an instruction completes
//  pc_wrap       out  1       1-cycle pulse when PC increments past 2^ADDR_W-1
// BEHAVIOUR
//  - Reset (reset==0, async): state=FETCH, pc=RESET_PC, acc=ir=mbr=0.
//    All pulses 0, mem_we=0. Takes effect mid-instruction with no partial commit.
//  - Instruction word: [15:12] op, [11:0] operand addr, zero-extended to ADDR_W.
//  - Ops and ALU opcodes:
//      0 HALT    1 LOAD    2 STORE   3 ADD(0000)   4 SUB(0001)   5 MUL(0010)
//      6 AND(1000)   7 OR(1001)    8 XOR(1010)   9 SHL(0100)   A SHR(0101)
//      B CMPGT(1110) C CMPEQ(1111) D JUMP        E JZ          F NOP
//  - mem_addr, mem_we, alu_opcode are combinational from state/IR.
//    mem_we=1 only in WRITE.
//  - FSM:
//      FETCH    mem_addr=pc, we=0; run ? ->LATCH : stay
//      LATCH    ir<=mem_rdata; pc<=pc+1 (wraps to 0, pulse pc_wrap); ->DECODE
//      DECODE   HALT->HALTED; NOP->FETCH+retire
//               JUMP: pc<=addr, ->FETCH+retire
//               JZ: if acc==0 pc<=addr, ->FETCH+retire
//               STORE->WRITE; SHL/SHR->EXEC; others->READ
//      READ     mem_addr=ir addr; ->CAPTURE
//      CAPTURE  mbr<=mem_rdata; LOAD: acc<=mem_rdata, ->FETCH+retire; else ->EXEC
//      EXEC     acc<=alu_result; ->FETCH+retire
//      WRITE    mem_addr=ir addr, mem_we=1, mem_wdata=acc; ->FETCH+retire
//      HALTED   stays; halted=1; exits only on reset
//  - retire is asserted on the edge leaving the final state, visible one cycle after.
//  - Latency: memory-operand ALU op 6 cycles; LOAD 5; STORE 4; shift 4;
//    JUMP/JZ/NOP 3.
//  - All arithmetic is modulo 2^DATA_W (ALU truncation); PC is modulo 2^ADDR_W.
//  - run sampled only in FETCH; deasserting it mid-instruction does not stall.
//  - JUMP to current PC is legal: infinite loop, retire pulses every 3 cycles.
// STRUCTURE
//  - Package cpu_pkg: state enum, OP_* constants, op->ALU-opcode function,
//    ALU_* opcode constants shared with ALU.
//  - One sub-module: seq_decoder (combinational).
//    ir[15:12] -> {alu_opcode, needs_read, is_store, is_branch, is_halt}.
//  - Registers and FSM live in instruction_sequencer.
// TESTING
//  1. Reset mid-EXEC of ADD -> next cycle pc=0, acc=0, mem_we=0, state FETCH.
//     No write to memory.
//  2. mem[0]=1100, mem[1]=3101, mem[0x100]=5, mem[0x101]=7, run=1
//     -> acc=12 after 11 cycles; retire pulsed twice.
//  3. mem[0]=1100 (mem[0x100]=0xBEEF), mem[1]=2200, mem[2]=0000
//     -> mem[0x200]=0xBEEF, halted=1, pc=3 stays.
//  4. acc=0, mem[0]=E040 -> pc=0x040 after 3 cycles.
//     Repeat with acc=1 -> pc=1.
//  5. RESET_PC=0x3FFF, mem[0x3FFF]=F000 -> pc_wrap pulse, pc=0 after LATCH.
//  6. run=0 for 10 cycles after reset -> pc stays 0, mem_addr=0, no retire;
//     run=1 -> fetch proceeds.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared types for the accumulator-machine sequencer: FSM states, instruction
// op codes, ALU opcodes (shared with the ALU) and the op->ALU opcode mapping.
package instruction_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_READ,
    S_CAPTURE,
    S_EXEC,
    S_WRITE,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_CMPGT = 4'hB;
  localparam logic [3:0] OP_CMPEQ = 4'hC;
  localparam logic [3:0] OP_JUMP  = 4'hD;
  localparam logic [3:0] OP_JZ    = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_SHL   = 4'b0100;
  localparam logic [3:0] ALU_SHR   = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_CMPGT = 4'b1110;
  localparam logic [3:0] ALU_CMPEQ = 4'b1111;

  // Non-ALU ops map to ADD; the ALU result is only committed in EXEC.
  function automatic logic [3:0] op_to_alu(input logic [3:0] op);
    case (op)
      OP_SUB:   op_to_alu = ALU_SUB;
      OP_MUL:   op_to_alu = ALU_MUL;
      OP_AND:   op_to_alu = ALU_AND;
      OP_OR:    op_to_alu = ALU_OR;
      OP_XOR:   op_to_alu = ALU_XOR;
      OP_SHL:   op_to_alu = ALU_SHL;
      OP_SHR:   op_to_alu = ALU_SHR;
      OP_CMPGT: op_to_alu = ALU_CMPGT;
      OP_CMPEQ: op_to_alu = ALU_CMPEQ;
      default:  op_to_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Memory and ALU bus between the sequencer (master) and MainMemory/ALU (slave).
interface instruction_sequencer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output mem_addr, mem_wdata, mem_we, alu_opcode, alu_operand1, alu_operand2,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, alu_opcode, alu_operand1, alu_operand2,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/instruction_sequencer_seq_decoder.sv
// Combinational op decode: ALU opcode plus the control class flags the FSM
// branches on in DECODE.
module instruction_sequencer_seq_decoder
  import instruction_sequencer_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_opcode,
  output logic       needs_read,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt
);

  always_comb begin
    alu_opcode = op_to_alu(op);
    needs_read = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
      OP_CMPGT, OP_CMPEQ:  needs_read = 1'b1;
      OP_STORE:            is_store   = 1'b1;
      OP_JUMP, OP_JZ:      is_branch  = 1'b1;
      OP_HALT:             is_halt    = 1'b1;
      default:             ;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit accumulator machine; owns
// PC, IR, MBR and ACC and commits ALU results into ACC.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  instruction_sequencer_if.master bus,
  output logic [ADDR_W-1:0]      pc,
  output logic [DATA_W-1:0]      acc,
  output logic                   halted,
  output logic                   retire,
  output logic                   pc_wrap
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir, mbr;
  logic [ADDR_W-1:0] opnd_addr;
  logic [ADDR_W:0]   pc_plus1;
  logic [3:0]        op;
  logic needs_read, is_store, is_branch, is_halt;
  logic ld_ir, ld_mbr, ld_acc_mem, ld_acc_alu, pc_inc_en, pc_jmp, retire_nxt;

  assign op        = ir[15:12];
  assign opnd_addr = {{(ADDR_W-12){1'b0}}, ir[11:0]};
  assign pc_plus1  = {1'b0, pc} + (ADDR_W+1)'(1);

  instruction_sequencer_seq_decoder u_dec (
    .op         (op),
    .alu_opcode (bus.alu_opcode),
    .needs_read (needs_read),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_halt    (is_halt)
  );

  assign bus.mem_wdata    = acc;
  assign bus.alu_operand1 = acc;
  assign bus.alu_operand2 = mbr;
  assign halted           = (state == S_HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.mem_addr = pc;
    bus.mem_we   = 1'b0;
    ld_ir        = 1'b0;
    ld_mbr       = 1'b0;
    ld_acc_mem   = 1'b0;
    ld_acc_alu   = 1'b0;
    pc_inc_en    = 1'b0;
    pc_jmp       = 1'b0;
    retire_nxt   = 1'b0;
    case (state)
      S_FETCH: if (run) state_nxt = S_LATCH;
      S_LATCH: begin
        ld_ir     = 1'b1;
        pc_inc_en = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt)         state_nxt = S_HALTED;
        else if (is_store)   state_nxt = S_WRITE;
        else if (needs_read) state_nxt = S_READ;
        else if (is_branch || op == OP_NOP) begin
          // JZ tests the ACC value as it stands entering DECODE.
          pc_jmp     = (op == OP_JUMP) || (op == OP_JZ && acc == '0);
          retire_nxt = 1'b1;
          state_nxt  = S_FETCH;
        end
        else                 state_nxt = S_EXEC;
      end
      S_READ: begin
        bus.mem_addr = opnd_addr;
        state_nxt    = S_CAPTURE;
      end
      S_CAPTURE: begin
        ld_mbr = 1'b1;
        if (op == OP_LOAD) begin
          ld_acc_mem = 1'b1;
          retire_nxt = 1'b1;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        ld_acc_alu = 1'b1;
        retire_nxt = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_WRITE: begin
        bus.mem_addr = opnd_addr;
        bus.mem_we   = 1'b1;
        retire_nxt   = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mbr     <= '0;
      acc     <= '0;
      retire  <= 1'b0;
      pc_wrap <= 1'b0;
    end else begin
      retire  <= retire_nxt;
      pc_wrap <= pc_inc_en & pc_plus1[ADDR_W];
      if (ld_ir)      ir  <= bus.mem_rdata;
      if (ld_mbr)     mbr <= bus.mem_rdata;
      if (ld_acc_mem) acc <= bus.mem_rdata;
      if (ld_acc_alu) acc <= bus.alu_result;
      if (pc_inc_en)  pc  <= pc_plus1[ADDR_W-1:0];
      else if (pc_jmp) pc <= opnd_addr;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench: two sequencers (RESET_PC 0 and 0x3FFF) each with a
// behavioural synchronous-read memory and combinational ALU.
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  logic clk, reset, run;
  logic [13:0] pc_a, pc_b;
  logic [15:0] acc_a, acc_b;
  logic halted_a, halted_b, retire_a, retire_b, pc_wrap_a, pc_wrap_b;

  logic [15:0] mem_a [0:16383];
  logic [15:0] mem_b [0:16383];
  int wr_cnt_a = 0;
  int vec_cnt = 0;
  int err_cnt = 0;

  instruction_sequencer_if #(.ADDR_W(14), .DATA_W(16)) bus_a ();
  instruction_sequencer_if #(.ADDR_W(14), .DATA_W(16)) bus_b ();

  instruction_sequencer #(.ADDR_W(14), .DATA_W(16), .RESET_PC(14'h0000)) dut_a (
    .clk(clk), .reset(reset), .run(run), .bus(bus_a), .pc(pc_a), .acc(acc_a),
    .halted(halted_a), .retire(retire_a), .pc_wrap(pc_wrap_a)
  );

  instruction_sequencer #(.ADDR_W(14), .DATA_W(16), .RESET_PC(14'h3FFF)) dut_b (
    .clk(clk), .reset(reset), .run(run), .bus(bus_b), .pc(pc_b), .acc(acc_b),
    .halted(halted_b), .retire(retire_b), .pc_wrap(pc_wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [3:0] opc, input logic [15:0] a,
                                        input logic [15:0] b);
    case (opc)
      4'b0000: alu_f = a + b;
      4'b0001: alu_f = a - b;
      4'b0010: alu_f = a * b;
      4'b0100: alu_f = a << 1;
      4'b0101: alu_f = a >> 1;
      4'b1000: alu_f = a & b;
      4'b1001: alu_f = a | b;
      4'b1010: alu_f = a ^ b;
      4'b1110: alu_f = {15'd0, a > b};
      4'b1111: alu_f = {15'd0, a == b};
      default: alu_f = 16'h0000;
    endcase
  endfunction

  always_comb bus_a.alu_result = alu_f(bus_a.alu_opcode, bus_a.alu_operand1, bus_a.alu_operand2);
  always_comb bus_b.alu_result = alu_f(bus_b.alu_opcode, bus_b.alu_operand1, bus_b.alu_operand2);

  always @(posedge clk) begin
    bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    if (bus_a.mem_we) begin
      mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
      wr_cnt_a++;
    end
  end

  always @(posedge clk) begin
    bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
    if (bus_b.mem_we) mem_b[bus_b.mem_addr] = bus_b.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    run   = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 16384; i++) mem_a[i] = 16'h0000;
  endtask

  initial begin
    int rets;
    int wr_snap;
    reset = 1'b0;
    run   = 1'b0;
    clear_mem_a();
    for (int i = 0; i < 16384; i++) mem_b[i] = 16'h0000;
    mem_b[14'h3FFF] = 16'hF000;

    // run held low: no fetch progress, then NOP retires once released
    mem_a[0] = 16'hF000;
    do_reset();
    chk("rst_pc", 32'(pc_a), 32'h0);
    chk("rst_acc", 32'(acc_a), 32'h0);
    chk("rst_we", 32'(bus_a.mem_we), 32'h0);
    chk("rst_halted", 32'(halted_a), 32'h0);
    rets = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      rets += int'(retire_a);
    end
    chk("idle_pc", 32'(pc_a), 32'h0);
    chk("idle_addr", 32'(bus_a.mem_addr), 32'h0);
    chk("idle_retire", 32'(rets), 32'h0);
    run = 1'b1;
    step(3);
    chk("nop_pc", 32'(pc_a), 32'h1);
    chk("nop_retire", 32'(retire_a), 32'h1);

    // reset in the middle of ADD's EXEC: nothing committed, nothing written
    clear_mem_a();
    mem_a[0] = 16'h3100;
    mem_a[16'h100] = 16'h0005;
    do_reset();
    wr_snap = wr_cnt_a;
    run = 1'b1;
    step(5);
    chk("mid_state", 32'(dut_a.state), 32'(S_EXEC));
    reset = 1'b0;
    #1;
    chk("mid_pc", 32'(pc_a), 32'h0);
    chk("mid_acc", 32'(acc_a), 32'h0);
    chk("mid_we", 32'(bus_a.mem_we), 32'h0);
    chk("mid_state_rst", 32'(dut_a.state), 32'(S_FETCH));
    repeat (2) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    reset = 1'b1;
    step(2);
    chk("mid_acc_after", 32'(acc_a), 32'h0);
    chk("mid_writes", 32'(wr_cnt_a - wr_snap), 32'h0);

    // LOAD 5 then ADD 7: 5 + 6 cycles
    clear_mem_a();
    mem_a[0] = 16'h1100;
    mem_a[1] = 16'h3101;
    mem_a[16'h100] = 16'h0005;
    mem_a[16'h101] = 16'h0007;
    do_reset();
    run = 1'b1;
    rets = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      rets += int'(retire_a);
    end
    chk("add_acc_c10", 32'(acc_a), 32'h5);
    step(1);
    rets += int'(retire_a);
    chk("add_acc_c11", 32'(acc_a), 32'hC);
    chk("add_retires", 32'(rets), 32'h2);

    // LOAD 0xBEEF, STORE 0x200, HALT
    clear_mem_a();
    mem_a[0] = 16'h1100;
    mem_a[1] = 16'h2200;
    mem_a[2] = 16'h0000;
    mem_a[16'h100] = 16'hBEEF;
    do_reset();
    run = 1'b1;
    step(11);
    chk("st_not_halted", 32'(halted_a), 32'h0);
    step(1);
    chk("st_mem", 32'(mem_a[16'h200]), 32'hBEEF);
    chk("st_halted", 32'(halted_a), 32'h1);
    chk("st_pc", 32'(pc_a), 32'h3);
    step(5);
    chk("st_pc_hold", 32'(pc_a), 32'h3);
    chk("st_halted_hold", 32'(halted_a), 32'h1);

    // JZ taken with acc==0, then not taken with acc==1 after looping back
    clear_mem_a();
    mem_a[0] = 16'hE040;
    mem_a[1] = 16'h0000;
    mem_a[16'h10] = 16'h0001;
    mem_a[16'h40] = 16'h1010;
    mem_a[16'h41] = 16'hD000;
    do_reset();
    run = 1'b1;
    step(3);
    chk("jz_taken_pc", 32'(pc_a), 32'h40);
    chk("jz_retire", 32'(retire_a), 32'h1);
    step(8);
    chk("jmp_pc", 32'(pc_a), 32'h0);
    chk("jmp_acc", 32'(acc_a), 32'h1);
    step(3);
    chk("jz_not_taken_pc", 32'(pc_a), 32'h1);

    // ALU mix: LOAD 5, SUB 7, SHL, XOR 0x00FF, OR 5, HALT
    clear_mem_a();
    mem_a[0] = 16'h1100;
    mem_a[1] = 16'h4101;
    mem_a[2] = 16'h9000;
    mem_a[3] = 16'h8102;
    mem_a[4] = 16'h7100;
    mem_a[5] = 16'h0000;
    mem_a[16'h100] = 16'h0005;
    mem_a[16'h101] = 16'h0007;
    mem_a[16'h102] = 16'h00FF;
    do_reset();
    run = 1'b1;
    step(11);
    chk("sub_wrap", 32'(acc_a), 32'hFFFE);
    step(4);
    chk("shl", 32'(acc_a), 32'hFFFC);
    step(6);
    chk("xor", 32'(acc_a), 32'hFF03);
    step(6);
    chk("or", 32'(acc_a), 32'hFF07);
    step(3);
    chk("mix_halted", 32'(halted_a), 32'h1);

    // PC wrap from 0x3FFF on the RESET_PC=0x3FFF instance
    do_reset();
    chk("wrap_rst_pc", 32'(pc_b), 32'h3FFF);
    run = 1'b1;
    step(1);
    chk("wrap_pulse_pre", 32'(pc_wrap_b), 32'h0);
    step(1);
    chk("wrap_pc", 32'(pc_b), 32'h0);
    chk("wrap_pulse", 32'(pc_wrap_b), 32'h1);
    step(1);
    chk("wrap_pulse_post", 32'(pc_wrap_b), 32'h0);
    chk("wrap_retire", 32'(retire_b), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
